// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default widths.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEFAULT = 7;
  localparam int VW_DEFAULT = 4;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   i_part,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW:0]   o_part,
  output logic          o_qbit
);

  logic [VW:0] w_shift;
  logic [VW:0] w_div_ext;

  // Trial subtraction; the incoming partial remainder is always below the
  // divisor, so its top bit is zero and the shifted value fits in VW+1 bits.
  always_comb begin
    w_shift   = {i_part[VW-1:0], i_bit};
    w_div_ext = {1'b0, i_divisor};
    if (w_shift >= w_div_ext) begin
      o_part = w_shift - w_div_ext;
      o_qbit = 1'b1;
    end else begin
      o_part = w_shift;
      o_qbit = 1'b0;
    end
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: IDLE/CALC/DONE FSM with one quotient
// bit per cycle, level-enable handshake and registered results.
module divider
  import divider_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int VW = VW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic          en,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        r_state;
  logic [DW-1:0] r_dividend;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_divisor;
  logic [VW:0]   r_part;
  logic [CW-1:0] r_cnt;

  logic [VW:0]   w_next_part;
  logic          w_qbit;

  div_step #(.VW(VW)) u_step (
    .i_part    (r_part),
    .i_bit     (r_dividend[DW-1]),
    .i_divisor (r_divisor),
    .o_part    (w_next_part),
    .o_qbit    (w_qbit)
  );

  // FSM, operand/partial registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dividend  <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_part      <= '0;
      r_cnt       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done        <= 1'b0;
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b0;
          if (en) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_part     <= '0;
            r_quot     <= '0;
            r_cnt      <= CW'(DW - 1);
            r_state    <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (!en) begin
            r_state    <= IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_part     <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
          end else if (r_divisor == '0) begin
            // Zero divisor short-circuits the iteration with the saturated result.
            r_state     <= DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
          end else begin
            r_part     <= w_next_part;
            r_dividend <= {r_dividend[DW-2:0], 1'b0};
            r_quot     <= {r_quot[DW-2:0], w_qbit};
            if (r_cnt == '0) begin
              r_state     <= DONE;
              done        <= 1'b1;
              quotient    <= {r_quot[DW-2:0], w_qbit};
              remainder   <= w_next_part[VW-1:0];
              div_by_zero <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        DONE: begin
          if (!en) begin
            r_state     <= IDLE;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          done        <= 1'b0;
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (DW=7, VW=4): vector table plus directed
// sequences for abort, reset, operand change and a random identity sweep.
module tb_divider;

  localparam int DW = 7;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int            edges;
  } vec_t;

  vec_t vecs[10];

  divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dividend    (dividend),
    .divisor     (divisor),
    .en          (en),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_q"}, {25'd0, quotient}, 32'd0);
    check({name, "_r"}, {28'd0, remainder}, 32'd0);
    check({name, "_z"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  // Raise en with the operands and count edges until done (bounded).
  task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b, output int edges);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    en       = 1'b1;
    edges    = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 40);
  endtask

  task automatic drop_en();
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    int seen;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;

    vecs[0] = '{7'd100, 4'd7,  7'd14,  4'd2, 1'b0, 8};
    vecs[1] = '{7'd127, 4'd15, 7'd8,   4'd7, 1'b0, 8};
    vecs[2] = '{7'd3,   4'd9,  7'd0,   4'd3, 1'b0, 8};
    vecs[3] = '{7'd45,  4'd0,  7'd127, 4'd0, 1'b1, 2};
    vecs[4] = '{7'd0,   4'd1,  7'd0,   4'd0, 1'b0, 8};
    vecs[5] = '{7'd127, 4'd1,  7'd127, 4'd0, 1'b0, 8};
    vecs[6] = '{7'd1,   4'd15, 7'd0,   4'd1, 1'b0, 8};
    vecs[7] = '{7'd126, 4'd14, 7'd9,   4'd0, 1'b0, 8};
    vecs[8] = '{7'd64,  4'd3,  7'd21,  4'd1, 1'b0, 8};
    vecs[9] = '{7'd15,  4'd15, 7'd1,   4'd0, 1'b0, 8};

    #12;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].a, vecs[i].b, edges);
      check($sformatf("v%0d_edges", i), edges, vecs[i].edges);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_q", i), {25'd0, quotient}, {25'd0, vecs[i].q});
      check($sformatf("v%0d_r", i), {28'd0, remainder}, {28'd0, vecs[i].r});
      check($sformatf("v%0d_z", i), {31'd0, div_by_zero}, {31'd0, vecs[i].z});
      // Holding en must keep the result and not restart.
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_hold_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_hold_q", i), {25'd0, quotient}, {25'd0, vecs[i].q});
      drop_en();
      check_cleared($sformatf("v%0d_clr", i));
    end

    // Abort: en dropped before edge 4 of 100/7.
    @(negedge clk);
    dividend = 7'd100;
    divisor  = 4'd7;
    en       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("abort");
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    run_div(7'd50, 4'd5, edges);
    check("after_abort_edges", edges, 8);
    check("after_abort_q", {25'd0, quotient}, 32'd10);
    check("after_abort_r", {28'd0, remainder}, 32'd0);
    drop_en();

    // Operands change to 0/0 after the capture edge.
    @(negedge clk);
    dividend = 7'd100;
    divisor  = 4'd7;
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 7'd0;
    divisor  = 4'd0;
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("opchg_edges", edges, 8);
    check("opchg_q", {25'd0, quotient}, 32'd14);
    check("opchg_r", {28'd0, remainder}, 32'd2);
    check("opchg_z", {31'd0, div_by_zero}, 32'd0);

    // Asynchronous reset while in DONE.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_done");
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-CALC, then no done without a new en.
    @(negedge clk);
    dividend = 7'd100;
    divisor  = 4'd7;
    en       = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_cleared("rst_calc");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("rst_no_done", seen, 0);
    run_div(7'd127, 4'd15, edges);
    check("after_rst_edges", edges, 8);
    check("after_rst_q", {25'd0, quotient}, 32'd8);
    check("after_rst_r", {28'd0, remainder}, 32'd7);
    drop_en();

    // Random sweep against the division identity.
    for (int k = 0; k < 1000; k++) begin
      ra = 7'($urandom_range(127, 0));
      rb = 4'($urandom_range(15, 1));
      run_div(ra, rb, edges);
      check($sformatf("rand%0d_%0d/%0d", k, ra, rb),
            {31'd0, (done === 1'b1) && (edges == 8) &&
                    (int'(quotient) * int'(rb) + int'(remainder) == int'(ra)) &&
                    (remainder < rb) && (quotient == ra / rb)},
            32'd1);
      drop_en();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
